// File: rtl/seg_roll_stats.sv
// rtl/seg_roll_stats.sv - seven-segment die receiver with stability filter and face histogram
//
// Purpose: samples the die's segment bus, accepts a pattern once it has been
// stable for STABLE_CYCLES registered samples, decodes it to a die face and
// keeps saturating per-face, total and error counters.
//
// Optional feature macro: ROLL_REPEAT_DETECT_EN (adds repeat_out).
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   seg_in      segment pattern, bit0=a .. bit6=g, active-high
//   clr         synchronous clear of all counters
//   sel         readout select: 0=total, 1..6=face count, 7=error count
//   valid_out   one-cycle pulse, valid face accepted
//   face_out    last accepted face 1..6, held between pulses
//   invalid_out one-cycle pulse, non-blank non-face pattern accepted
//   count_out   registered counter selected by sel
//   busy_out    high while waiting for a pattern to stabilise
//   repeat_out  (ROLL_REPEAT_DETECT_EN) pulses with valid_out when face repeats

module seg_roll_stats #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       seg_in,
   input  logic             clr,
   input  logic [2:0]       sel,
   output logic             valid_out,
   output logic [2:0]       face_out,
   output logic             invalid_out,
   output logic [CNT_W-1:0] count_out,
   output logic             busy_out
`ifdef ROLL_REPEAT_DETECT_EN
   ,
   output logic             repeat_out
`endif
);

   localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);
   localparam logic [3:0] STAB_PRE = 4'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [2:0] decode_face(input logic [6:0] seg);
      case (seg)
         7'h06:   decode_face = 3'd1;
         7'h5B:   decode_face = 3'd2;
         7'h4F:   decode_face = 3'd3;
         7'h66:   decode_face = 3'd4;
         7'h6D:   decode_face = 3'd5;
         7'h7D:   decode_face = 3'd6;
         default: decode_face = 3'd0;
      endcase
   endfunction

   // 00 is the display off, 3F is the "0" glyph the driver shows when the die is idle
   function automatic logic is_blank(input logic [6:0] seg);
      is_blank = (seg == 7'h00) || (seg == 7'h3F);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      sat_inc = (&v) ? v : v + 1'b1;
   endfunction

   logic [6:0]       seg_q;
   logic [3:0]       stab_cnt_q, stab_cnt_d;
   state_t           state_q, state_d;
   logic             valid_q, invalid_q;
   logic [2:0]       face_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] cnt_q [0:7];
   logic [CNT_W-1:0] cnt_d [0:7];

   logic       changed;
   logic       accept;
   logic       new_blank;
   logic [2:0] face_dec;
   logic       ev_valid;
   logic       ev_invalid;

   // A change is seen as the new sample enters seg_q on this edge
   assign changed   = (seg_in != seg_q);
   assign new_blank = is_blank(seg_in);
   assign accept    = !changed && (stab_cnt_q == STAB_PRE);
   assign face_dec  = decode_face(seg_q);

   // WAIT is only entered on a non-blank pattern and left on any change,
   // so an accept in WAIT is always for a non-blank pattern
   assign ev_valid   = (state_q == WAIT) && accept && (face_dec != 3'd0);
   assign ev_invalid = (state_q == WAIT) && accept && (face_dec == 3'd0);

   always_comb begin
      stab_cnt_d = stab_cnt_q;
      if (changed)
         stab_cnt_d = 4'd1;
      else if (stab_cnt_q != STAB_MAX)
         stab_cnt_d = stab_cnt_q + 4'd1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (changed && !new_blank)
               state_d = WAIT;
         end
         WAIT: begin
            if (changed)
               state_d = new_blank ? IDLE : WAIT;
            else if (accept)
               state_d = LOCKED;
         end
         LOCKED: begin
            if (changed)
               state_d = new_blank ? IDLE : WAIT;
         end
         default: state_d = IDLE;
      endcase
   end

   // Index 0 = total, 1..6 = faces, 7 = errors; clr overrides any increment
   always_comb begin
      for (int i = 0; i < 8; i++)
         cnt_d[i] = cnt_q[i];
      if (ev_valid) begin
         cnt_d[0]        = sat_inc(cnt_q[0]);
         cnt_d[face_dec] = sat_inc(cnt_q[face_dec]);
      end
      if (ev_invalid)
         cnt_d[7] = sat_inc(cnt_q[7]);
      if (clr) begin
         for (int i = 0; i < 8; i++)
            cnt_d[i] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q      <= '0;
         stab_cnt_q <= '0;
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         invalid_q  <= 1'b0;
         face_q     <= '0;
         count_q    <= '0;
         for (int i = 0; i < 8; i++)
            cnt_q[i] <= '0;
      end else begin
         seg_q      <= seg_in;
         stab_cnt_q <= stab_cnt_d;
         state_q    <= state_d;
         valid_q    <= ev_valid;
         invalid_q  <= ev_invalid;
         if (ev_valid)
            face_q <= face_dec;
         // Readout reflects counter values from before this edge
         count_q <= cnt_q[sel];
         for (int i = 0; i < 8; i++)
            cnt_q[i] <= cnt_d[i];
      end
   end

   assign valid_out   = valid_q;
   assign invalid_out = invalid_q;
   assign face_out    = face_q;
   assign count_out   = count_q;
   assign busy_out    = (state_q == WAIT);

`ifdef ROLL_REPEAT_DETECT_EN
   logic [2:0] hist_q;
   logic       repeat_q;

   // hist_q of 0 never matches a face, so the first accept after reset/clr never flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_q   <= '0;
         repeat_q <= 1'b0;
      end else begin
         repeat_q <= ev_valid && (face_dec == hist_q);
         if (clr)
            hist_q <= '0;
         else if (ev_valid)
            hist_q <= face_dec;
      end
   end

   assign repeat_out = repeat_q;
`endif

endmodule

// File: tb/tb_seg_roll_stats.sv
// tb/tb_seg_roll_stats.sv - directed self-checking bench for seg_roll_stats

module tb_seg_roll_stats;

   logic       clk;
   logic       rst_n;
   logic [6:0] seg_in;
   logic       clr;
   logic [2:0] sel;
   logic       valid_out;
   logic [2:0] face_out;
   logic       invalid_out;
   logic [7:0] count_out;
   logic       busy_out;
`ifdef ROLL_REPEAT_DETECT_EN
   logic       repeat_out;
`endif

   int errors = 0;
   int checks = 0;
   int n_valid = 0;
   int n_invalid = 0;
   int busy_low = 0;

   seg_roll_stats #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .clr         (clr),
      .sel         (sel),
      .valid_out   (valid_out),
      .face_out    (face_out),
      .invalid_out (invalid_out),
      .count_out   (count_out),
      .busy_out    (busy_out)
`ifdef ROLL_REPEAT_DETECT_EN
      ,
      .repeat_out  (repeat_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample registered outputs 1 ns later
   task automatic tick();
      @(posedge clk);
      #1;
      n_valid   += int'(valid_out);
      n_invalid += int'(invalid_out);
   endtask

   task automatic hold(input logic [6:0] g, input int n);
      seg_in = g;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic read_cnt(input logic [2:0] s, input string tag, input int exp);
      sel = s;
      tick();
      chk(tag, count_out, exp);
   endtask

   initial begin
      rst_n  = 1'b0;
      seg_in = 7'h00;
      clr    = 1'b0;
      sel    = 3'd0;
      tick();
      tick();
      chk("rst_valid", valid_out, 0);
      chk("rst_invalid", invalid_out, 0);
      chk("rst_face", face_out, 0);
      chk("rst_count", count_out, 0);
      chk("rst_busy", busy_out, 0);
      rst_n = 1'b1;
      hold(7'h00, 3);
      n_valid = 0;
      n_invalid = 0;

      // Face 6: pulse appears after the 4th edge with 7D held
      seg_in = 7'h7D;
      tick(); tick(); tick();
      chk("f6_early", n_valid, 0);
      tick();
      chk("f6_pulse", valid_out, 1);
      tick(); tick();
      chk("f6_single", n_valid, 1);
      chk("f6_face", face_out, 6);
      read_cnt(3'd6, "f6_cnt6", 1);
      read_cnt(3'd0, "f6_total", 1);

      // Alternating patterns never settle
      n_valid = 0;
      busy_low = 0;
      for (int i = 0; i < 10; i++) begin
         hold((i % 2 == 0) ? 7'h06 : 7'h5B, 2);
         if (!busy_out) busy_low++;
      end
      chk("alt_busy_low", busy_low, 0);
      chk("alt_no_pulse", n_valid, 0);
      hold(7'h00, 5);
      chk("alt_idle_busy", busy_out, 0);
      read_cnt(3'd1, "alt_cnt1", 0);
      read_cnt(3'd2, "alt_cnt2", 0);

      // Face 4 twice through a blank gap, then a long steady run
      n_valid = 0;
      hold(7'h66, 5);
      hold(7'h00, 5);
      hold(7'h66, 5);
      chk("f4_two_pulses", n_valid, 2);
      chk("f4_face", face_out, 4);
      read_cnt(3'd4, "f4_cnt4", 2);
      hold(7'h00, 5);
      n_valid = 0;
      hold(7'h66, 50);
      chk("f4_steady_one", n_valid, 1);
      read_cnt(3'd4, "f4_cnt4_b", 3);

      // "8" glyph is invalid
      n_valid = 0;
      n_invalid = 0;
      hold(7'h7F, 6);
      chk("inv_pulses", n_invalid, 1);
      chk("inv_no_valid", n_valid, 0);
      chk("inv_face_held", face_out, 4);
      read_cnt(3'd7, "inv_err", 1);
      read_cnt(3'd0, "inv_total", 4);

      // Saturation of face 2 and total
      n_valid = 0;
      for (int i = 0; i < 300; i++) begin
         hold(7'h5B, 4);
         hold(7'h00, 1);
      end
      chk("sat_pulses", n_valid, 300);
      read_cnt(3'd2, "sat_cnt2", 255);
      read_cnt(3'd0, "sat_total", 255);

      // clr on the edge of accept 301
      seg_in = 7'h5B;
      tick(); tick(); tick();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_valid", valid_out, 1);
      chk("clr_face", face_out, 2);
      read_cnt(3'd2, "clr_cnt2", 0);
      read_cnt(3'd0, "clr_total", 0);
      read_cnt(3'd7, "clr_err", 0);

`ifdef ROLL_REPEAT_DETECT_EN
      seg_in = 7'h4F;
      tick(); tick(); tick(); tick();
      chk("rep_first_valid", valid_out, 1);
      chk("rep_first", repeat_out, 0);
      hold(7'h00, 1);
      seg_in = 7'h4F;
      tick(); tick(); tick(); tick();
      chk("rep_second", repeat_out, 1);
      hold(7'h00, 1);
      seg_in = 7'h6D;
      tick(); tick(); tick(); tick();
      chk("rep_third", repeat_out, 0);
      hold(7'h00, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      seg_in = 7'h6D;
      tick(); tick(); tick(); tick();
      chk("rep_after_clr_valid", valid_out, 1);
      chk("rep_after_clr", repeat_out, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seg_roll_stats.md
Name: seg_roll_stats

Overview:
Receive side of the die's seven-segment output bus. The block watches the 7-bit segment pattern and requires it to be stable before accepting it. It decodes accepted glyphs back to die faces 1-6 and keeps saturating per-face histogram counters, readable through a select port. It sits downstream of the die/display driver, either on-chip as a self-test monitor or in a companion tile fed from the segment pins.

Parameters:
STABLE_CYCLES, 4, consecutive identical registered samples needed to accept a pattern (legal range 2..15)
CNT_W, 8, width of every histogram, total and error counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
seg_in  in  7  segment pattern, active-high, bit0=a .. bit6=g
clr  in  1  synchronous clear of all counters
sel  in  3  readout select: 0=total, 1..6=face count, 7=error count
valid_out  out  1  one-cycle pulse: valid face accepted
face_out  out  3  last accepted face 1..6, held between pulses
invalid_out  out  1  one-cycle pulse: non-blank, non-face pattern accepted
count_out  out  CNT_W  registered counter selected by sel
busy_out  out  1  high while state is WAIT

Behaviour:
- Reset (rst_n=0 at a clk edge) sets all of the following to 0: seg_q, stab_cnt, all counters, valid_out, invalid_out, face_out, count_out, busy_out. State goes to IDLE.
- Face glyph table (hex, g..a): 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D. Blank patterns are 00 and 3F ("0" glyph = die off). Every other pattern is invalid.
- seg_q registers seg_in every cycle. stab_cnt tracks consecutive identical samples:
  - If seg_q changes, stab_cnt becomes 1.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
- Accept event: fires on the edge where stab_cnt goes from STABLE_CYCLES-1 to STABLE_CYCLES. It fires once per stable run.
- FSM:
  - IDLE: on a change to a non-blank pattern, go to WAIT.
  - WAIT: on accept go to LOCKED. If the pattern changes before accept, stay in WAIT and restart the count. If the pattern changes to blank, go to IDLE.
  - LOCKED: on any pattern change, go to WAIT if the new pattern is non-blank, or IDLE if it is blank. The same glyph must be interrupted by a different pattern before it can be counted again.
  - Accepting a blank pattern produces no event.
- Latency: if seg_in holds new value P from before edge k, then valid_out or invalid_out is high during the cycle following edge k+STABLE_CYCLES-1, for exactly one cycle.
- On a valid accept, in the same edge:
  - face_out is set to the face.
  - cnt[face] increments.
  - total increments.
- On an invalid accept: err increments; face_out is unchanged.
- All counters saturate at 2^CNT_W-1 and never wrap.
- clr: clears all counters on that edge. clr wins over a simultaneous increment, so the counter ends at 0. The valid_out/invalid_out pulse and the face_out update still occur. clr does not affect the FSM or stab_cnt.
- count_out = counter[sel], registered: 1-cycle latency from a sel change, and it reflects counter values after the previous edge.
- face_out, valid_out and invalid_out are registered outputs.

Optional Feature:
ROLL_REPEAT_DETECT_EN
- Defined: adds output repeat_out (1 bit).
  - Pulses together with valid_out when the accepted face equals the previous valid accepted face.
  - Its history register is cleared by reset and by clr, so the first accept after either never flags.
- Undefined: the port and its history register do not exist; all other behaviour is identical.

Test Plan:
- Reset, then hold seg_in=7D for 6 cycles -> exactly one valid_out pulse 4 cycles after seg_q first holds 7D; face_out=6; sel=6 gives count_out=1; sel=0 gives count_out=1.
- seg_in alternates 06/5B every 2 cycles for 20 cycles -> no valid_out, busy_out high throughout, all counters 0.
- Apply 66 for 5 cycles, 00 for 5 cycles, 66 for 5 cycles -> two pulses with face_out=4, cnt4=2. A steady 66 held for 50 cycles -> only one pulse.
- Apply seg_in=7F (the "8" glyph) stable -> invalid_out pulses once; sel=7 gives 1; face_out unchanged; total unchanged.
- With CNT_W=8, run 300 accepts of face 2 -> cnt2=255 and total=255; then assert clr on the same edge as accept 301 -> cnt2=0 and total=0, valid_out still pulses.
- ROLL_REPEAT_DETECT_EN defined: accept sequence 3,3,5 -> repeat_out pulses on the second accept only; after clr, accept 5 -> no repeat_out.
